multi_channel_coupling_controller: RTL

MULTI_CHANNEL_COUPLING_CONTROLLER -- requirements
Module: multi_channel_coupling_controller

---
 rtl/multi_channel_coupling_controller.sv | 289 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/multi_channel_coupling_controller.sv
// multi_channel_coupling_controller
//
// Purpose: per-channel coupling-mode manager. Each channel moves between
// MODULATORY and HARMONIC coupling through a timed TRANSITION state. Moves are
// driven by debounced Kuramoto-sync / boundary-power thresholds, with an
// optional SIE phase override. A shared admission limit caps how many channels
// may be in (or heading toward) HARMONIC at once. PAC and harmonic gains slew
// toward per-mode targets at a fixed step per tick.
//
// Ports:
//   clk, rst                 clock; synchronous active-high reset
//   clk_en                   tick enable; every register holds while low
//   ch_enable[N_CH]          per-channel enable mask
//   kuramoto_R               packed signed Q14 sync metric, channel k at [k*WIDTH +: WIDTH]
//   boundary_power           packed signed Q14 boundary power, same packing
//   sie_phase[3]             shared SIE phase (2..4 active, 5 decay)
//   r_high_thresh, r_low_thresh, boundary_thresh
//                            shared thresholds; 0 selects the built-in default
//   coupling_mode[2*N_CH]    per-channel mode: 00 MODULATORY, 01 TRANSITION, 10 HARMONIC
//   pac_gain, harmonic_gain  packed per-channel Q14 gains
//   mode_transition_active   high while the channel is in TRANSITION
//   harmonic_count[4]        channels in HARMONIC or in TRANSITION heading up
module multi_channel_coupling_controller #(
  parameter int WIDTH             = 18,
  parameter int FRAC              = 14,
  parameter int N_CH              = 4,
  parameter int TRANSITION_CYCLES = 100,
  parameter int DEBOUNCE_CYCLES   = 20,
  parameter int RAMP_STEP         = 8,
  parameter int MAX_HARMONIC      = N_CH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clk_en,
  input  logic [N_CH-1:0]        ch_enable,
  input  logic [N_CH*WIDTH-1:0]  kuramoto_R,
  input  logic [N_CH*WIDTH-1:0]  boundary_power,
  input  logic [2:0]             sie_phase,
  input  logic [WIDTH-1:0]       r_high_thresh,
  input  logic [WIDTH-1:0]       r_low_thresh,
  input  logic [WIDTH-1:0]       boundary_thresh,
  output logic [2*N_CH-1:0]      coupling_mode,
  output logic [N_CH*WIDTH-1:0]  pac_gain,
  output logic [N_CH*WIDTH-1:0]  harmonic_gain,
  output logic [N_CH-1:0]        mode_transition_active,
  output logic [3:0]             harmonic_count
);

  typedef enum logic [1:0] {
    MODE_MOD   = 2'b00,
    MODE_TRANS = 2'b01,
    MODE_HARM  = 2'b10
  } mode_t;

  localparam int DW = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TW = (TRANSITION_CYCLES < 2) ? 1 : $clog2(TRANSITION_CYCLES);

  localparam logic [DW-1:0] DEB_MAX = DW'(DEBOUNCE_CYCLES);
  localparam logic [TW-1:0] T_LAST  = TW'(TRANSITION_CYCLES - 1);
  localparam logic [4:0]    MAX_H   = 5'(MAX_HARMONIC);

  // Gain levels expressed in Q(FRAC): 1.0, 0.5 and 0.125.
  localparam logic signed [WIDTH-1:0] GAIN_ONE  = WIDTH'(1 << FRAC);
  localparam logic signed [WIDTH-1:0] GAIN_HALF = WIDTH'(1 << (FRAC - 1));
  localparam logic signed [WIDTH-1:0] GAIN_LOW  = WIDTH'(1 << (FRAC - 3));
  localparam logic signed [WIDTH-1:0] STEP_W    = WIDTH'(RAMP_STEP);
  localparam logic signed [WIDTH:0]   STEP_E    = (WIDTH + 1)'(RAMP_STEP);

  localparam logic signed [WIDTH-1:0] R_HIGH_DEF  = WIDTH'(9011);
  localparam logic signed [WIDTH-1:0] R_LOW_DEF   = WIDTH'(5734);
  localparam logic signed [WIDTH-1:0] B_ENTRY_DEF = WIDTH'(4915);
  localparam logic signed [WIDTH-1:0] B_EXIT_DEF  = WIDTH'(2458);

  mode_t                   mode_q  [N_CH];
  mode_t                   mode_d  [N_CH];
  logic                    dir_up_q[N_CH];
  logic                    dir_up_d[N_CH];
  logic [DW-1:0]           deb_q   [N_CH];
  logic [DW-1:0]           deb_d   [N_CH];
  logic [TW-1:0]           tcnt_q  [N_CH];
  logic [TW-1:0]           tcnt_d  [N_CH];
  logic signed [WIDTH-1:0] pac_q   [N_CH];
  logic signed [WIDTH-1:0] pac_d   [N_CH];
  logic signed [WIDTH-1:0] harm_q  [N_CH];
  logic signed [WIDTH-1:0] harm_d  [N_CH];
  logic [3:0]              harmonic_count_q;
  logic [3:0]              harmonic_count_d;

  logic signed [WIDTH-1:0] r_high, r_low, b_entry, b_exit;
  logic signed [WIDTH-1:0] r_ch[N_CH];
  logic signed [WIDTH-1:0] b_ch[N_CH];
  logic [N_CH-1:0]         raw_entry, raw_exit;
  logic                    sie_active, sie_decay;

  // Saturating debounce step: clears whenever the watched condition fails.
  function automatic logic [DW-1:0] sat_inc(input logic [DW-1:0] v, input logic holds);
    if (!holds)          return '0;
    if (v == DEB_MAX)    return DEB_MAX;
    return v + 1'b1;
  endfunction

  // Slew toward the target by one step, landing exactly when within a step.
  function automatic logic signed [WIDTH-1:0] ramp(input logic signed [WIDTH-1:0] cur,
                                                    input logic signed [WIDTH-1:0] tgt);
    logic signed [WIDTH:0] err;
    err = {tgt[WIDTH-1], tgt} - {cur[WIDTH-1], cur};
    if (err > STEP_E)       return cur + STEP_W;
    else if (err < -STEP_E) return cur - STEP_W;
    else                    return tgt;
  endfunction

  // Threshold selection; the exit boundary tracks half the programmed entry
  // boundary (arithmetic shift keeps the sign) when one is supplied.
  always_comb begin
    r_high  = (r_high_thresh   == '0) ? R_HIGH_DEF  : r_high_thresh;
    r_low   = (r_low_thresh    == '0) ? R_LOW_DEF   : r_low_thresh;
    b_entry = (boundary_thresh == '0) ? B_ENTRY_DEF : boundary_thresh;
    b_exit  = (boundary_thresh == '0) ? B_EXIT_DEF
                                      : {boundary_thresh[WIDTH-1], boundary_thresh[WIDTH-1:1]};
    sie_active = (sie_phase >= 3'd2) && (sie_phase <= 3'd4);
    sie_decay  = (sie_phase == 3'd5);
  end

  // Raw, undebounced entry/exit conditions per channel (signed compares).
  always_comb begin
    for (int k = 0; k < N_CH; k++) begin
      r_ch[k]      = kuramoto_R[k*WIDTH +: WIDTH];
      b_ch[k]      = boundary_power[k*WIDTH +: WIDTH];
      raw_entry[k] = (r_ch[k] >= r_high) && (b_ch[k] >= b_entry);
      raw_exit[k]  = ((r_ch[k] < r_low) && (b_ch[k] < b_exit)) ||
                     (sie_decay && (r_ch[k] < r_low));
    end
  end

  // Mode state machine. Channels are visited in index order so that
  // admission grants to lower indices count against higher ones within the
  // same tick. Any request to head toward HARMONIC (fresh entry, reversal, or
  // SIE force) passes through the same admission check. The debounce counter
  // restarts whenever the watched condition changes meaning (new direction).
  always_comb begin
    logic [4:0] up_count;
    logic       opposing;
    logic       want_up;
    up_count = {1'b0, harmonic_count_q};
    for (int k = 0; k < N_CH; k++) begin
      mode_d[k]   = mode_q[k];
      dir_up_d[k] = dir_up_q[k];
      deb_d[k]    = deb_q[k];
      tcnt_d[k]   = tcnt_q[k];
      opposing    = 1'b0;
      want_up     = 1'b0;
      if (!ch_enable[k]) begin
        mode_d[k]   = MODE_MOD;
        dir_up_d[k] = 1'b0;
        deb_d[k]    = '0;
        tcnt_d[k]   = '0;
      end else begin
        case (mode_q[k])
          MODE_MOD: begin
            deb_d[k] = sat_inc(deb_q[k], raw_entry[k]);
            want_up  = sie_active || (raw_entry[k] && (deb_q[k] == DEB_MAX));
            if (want_up && (up_count < MAX_H)) begin
              up_count    = up_count + 5'd1;
              mode_d[k]   = MODE_TRANS;
              dir_up_d[k] = 1'b1;
              tcnt_d[k]   = '0;
              deb_d[k]    = '0;
            end
          end
          MODE_HARM: begin
            opposing = raw_exit[k] && !sie_active;
            deb_d[k] = sat_inc(deb_q[k], opposing);
            if (opposing && (deb_q[k] == DEB_MAX)) begin
              mode_d[k]   = MODE_TRANS;
              dir_up_d[k] = 1'b0;
              tcnt_d[k]   = '0;
              deb_d[k]    = '0;
            end
          end
          MODE_TRANS: begin
            if (dir_up_q[k]) begin
              opposing = raw_exit[k] && !sie_active;
              deb_d[k] = sat_inc(deb_q[k], opposing);
              if (opposing && (deb_q[k] == DEB_MAX)) begin
                dir_up_d[k] = 1'b0;
                tcnt_d[k]   = T_LAST - tcnt_q[k];
                deb_d[k]    = '0;
              end else if (tcnt_q[k] == T_LAST) begin
                mode_d[k] = MODE_HARM;
                tcnt_d[k] = '0;
              end else begin
                tcnt_d[k] = tcnt_q[k] + 1'b1;
              end
            end else begin
              opposing = raw_entry[k];
              deb_d[k] = sat_inc(deb_q[k], opposing);
              want_up  = sie_active || (opposing && (deb_q[k] == DEB_MAX));
              if (want_up && (up_count < MAX_H)) begin
                up_count    = up_count + 5'd1;
                dir_up_d[k] = 1'b1;
                tcnt_d[k]   = T_LAST - tcnt_q[k];
                deb_d[k]    = '0;
              end else if (tcnt_q[k] == T_LAST) begin
                mode_d[k] = MODE_MOD;
                tcnt_d[k] = '0;
              end else begin
                tcnt_d[k] = tcnt_q[k] + 1'b1;
              end
            end
          end
          default: begin
            mode_d[k]   = MODE_MOD;
            dir_up_d[k] = 1'b0;
            deb_d[k]    = '0;
            tcnt_d[k]   = '0;
          end
        endcase
      end
    end
  end

  // Occupancy of the HARMONIC budget after this tick's moves.
  always_comb begin
    harmonic_count_d = '0;
    for (int k = 0; k < N_CH; k++) begin
      if ((mode_d[k] == MODE_HARM) || ((mode_d[k] == MODE_TRANS) && dir_up_d[k]))
        harmonic_count_d = harmonic_count_d + 4'd1;
    end
  end

  // Gains chase the targets of the mode being entered, so a slew starts on
  // the same tick the mode change is registered.
  always_comb begin
    for (int k = 0; k < N_CH; k++) begin
      case (mode_d[k])
        MODE_HARM: begin
          pac_d[k]  = ramp(pac_q[k],  GAIN_LOW);
          harm_d[k] = ramp(harm_q[k], GAIN_ONE);
        end
        MODE_TRANS: begin
          pac_d[k]  = ramp(pac_q[k],  GAIN_HALF);
          harm_d[k] = ramp(harm_q[k], GAIN_HALF);
        end
        default: begin
          pac_d[k]  = ramp(pac_q[k],  GAIN_ONE);
          harm_d[k] = ramp(harm_q[k], GAIN_LOW);
        end
      endcase
    end
  end

  // All state advances only on enabled ticks; reset discards any transition
  // progress and snaps gains to their MODULATORY values.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N_CH; k++) begin
        mode_q[k]   <= MODE_MOD;
        dir_up_q[k] <= 1'b0;
        deb_q[k]    <= '0;
        tcnt_q[k]   <= '0;
        pac_q[k]    <= GAIN_ONE;
        harm_q[k]   <= GAIN_LOW;
      end
      harmonic_count_q <= '0;
    end else if (clk_en) begin
      for (int k = 0; k < N_CH; k++) begin
        mode_q[k]   <= mode_d[k];
        dir_up_q[k] <= dir_up_d[k];
        deb_q[k]    <= deb_d[k];
        tcnt_q[k]   <= tcnt_d[k];
        pac_q[k]    <= pac_d[k];
        harm_q[k]   <= harm_d[k];
      end
      harmonic_count_q <= harmonic_count_d;
    end
  end

  // Outputs are straight flop taps.
  always_comb begin
    for (int k = 0; k < N_CH; k++) begin
      coupling_mode[2*k +: 2]          = mode_q[k];
      pac_gain[k*WIDTH +: WIDTH]       = pac_q[k];
      harmonic_gain[k*WIDTH +: WIDTH]  = harm_q[k];
      mode_transition_active[k]        = (mode_q[k] == MODE_TRANS);
    end
    harmonic_count = harmonic_count_q;
  end

endmodule
